// File: rtl/sap2_bus_pkg.sv
// rtl/sap2_bus_pkg.sv - shared state encoding, source indices and decision codes for the bus arbiter
package sap2_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    BACKOFF = 2'd2
  } arb_state_e;

  // One code per priority rung resolved on each edge
  typedef enum logic [2:0] {
    ACT_IDLE    = 3'd0,
    ACT_CTRL    = 3'd1,
    ACT_BAD     = 3'd2,
    ACT_HOLD    = 3'd3,
    ACT_TMO     = 3'd4,
    ACT_BACKOFF = 3'd5,
    ACT_GRANT   = 3'd6
  } arb_act_e;

  localparam int A_REG = 0;
  localparam int T_REG = 1;
  localparam int B_REG = 2;
  localparam int C_REG = 3;
  localparam int RAM   = 4;
  localparam int STACK = 5;
  localparam int MDR   = 6;
  localparam int ALU   = 7;
  localparam int PC    = 8;

  localparam int NUM_BUS_SRC = 9;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first set request at or after ptr, wrapping
module rr_pick #(
  parameter int N = 9,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  int j;

  // Scan from farthest to nearest so the closest hit to ptr is written last
  always_comb begin
    found  = |req;
    idx    = '0;
    onehot = '0;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        idx       = W'(j);
        onehot    = '0;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shared-bus owner sequencer: microcode priority, round robin, lock with watchdog
module bus_arbiter
  import sap2_bus_pkg::*;
#(
  parameter int NUM_REQ = NUM_BUS_SRC,
  parameter int TIMEOUT = 16,
  parameter int OWN_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_lock,
  input  logic               i_ctrl_valid,
  input  logic [NUM_REQ-1:0] i_ctrl_sel,
  input  logic               i_err_clr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_busy,
  output logic [OWN_W-1:0]   o_owner,
  output logic               o_timeout,
  output logic               o_onehot_err
);

  localparam int HOLD_W = $clog2(TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIMEOUT - 1);

  arb_state_e         state, state_d;
  arb_act_e           act;
  logic               ctrl_own, ctrl_own_d;
  logic [OWN_W-1:0]   rr_ptr, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [OWN_W-1:0]   owner_d;
  logic               timeout_d, err_d;

  logic               pick_found;
  logic [OWN_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               ctrl_any, ctrl_ok, owner_locked;
  logic [OWN_W-1:0]   ctrl_idx;
  logic [NUM_REQ-1:0] ctrl_first;

  function automatic logic [OWN_W-1:0] next_ptr(input logic [OWN_W-1:0] idx);
    return (idx == OWN_W'(NUM_REQ - 1)) ? '0 : idx + OWN_W'(1);
  endfunction

  rr_pick #(.N(NUM_REQ), .W(OWN_W)) u_pick (
    .req    (i_req),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Fixed-origin scan of the control word: one-hot exactly when its lowest set bit is the whole word
  rr_pick #(.N(NUM_REQ), .W(OWN_W)) u_ctrl_enc (
    .req    (i_ctrl_sel),
    .ptr    ('0),
    .found  (ctrl_any),
    .idx    (ctrl_idx),
    .onehot (ctrl_first)
  );

  assign ctrl_ok      = ctrl_any && (ctrl_first == i_ctrl_sel);
  assign owner_locked = (state == OWN) && !ctrl_own && i_req[o_owner] && i_lock[o_owner];
  assign o_busy       = |o_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      ctrl_own     <= 1'b0;
      rr_ptr       <= '0;
      hold_cnt     <= '0;
      o_gnt        <= '0;
      o_owner      <= '0;
      o_timeout    <= 1'b0;
      o_onehot_err <= 1'b0;
    end else begin
      state        <= state_d;
      ctrl_own     <= ctrl_own_d;
      rr_ptr       <= rr_ptr_d;
      hold_cnt     <= hold_cnt_d;
      o_gnt        <= gnt_d;
      o_owner      <= owner_d;
      o_timeout    <= timeout_d;
      o_onehot_err <= err_d;
    end
  end

  always_comb begin
    act     = ACT_IDLE;
    state_d = IDLE;
    if (i_ctrl_valid) begin
      if (ctrl_ok) begin
        act     = ACT_CTRL;
        state_d = OWN;
      end else begin
        act = ACT_BAD;
      end
    end else if (owner_locked) begin
      if (hold_cnt < HOLD_MAX) begin
        act     = ACT_HOLD;
        state_d = OWN;
      end else begin
        act     = ACT_TMO;
        state_d = BACKOFF;
      end
    end else if (state == BACKOFF) begin
      act = ACT_BACKOFF;
    end else if (pick_found) begin
      act     = ACT_GRANT;
      state_d = OWN;
    end
  end

  always_comb begin
    gnt_d      = '0;
    owner_d    = '0;
    timeout_d  = 1'b0;
    ctrl_own_d = 1'b0;
    rr_ptr_d   = rr_ptr;
    hold_cnt_d = '0;
    err_d      = o_onehot_err & ~i_err_clr;
    case (act)
      ACT_CTRL: begin
        gnt_d      = i_ctrl_sel;
        owner_d    = ctrl_idx;
        ctrl_own_d = 1'b1;
      end
      ACT_BAD: err_d = 1'b1;
      ACT_HOLD: begin
        gnt_d      = o_gnt;
        owner_d    = o_owner;
        hold_cnt_d = hold_cnt + HOLD_W'(1);
      end
      ACT_TMO: begin
        timeout_d = 1'b1;
        rr_ptr_d  = next_ptr(o_owner);
      end
      ACT_GRANT: begin
        gnt_d    = pick_onehot;
        owner_d  = pick_idx;
        rr_ptr_d = next_ptr(pick_idx);
      end
      default: ;
    endcase
  end

endmodule
